// File: rtl/event_hs_receiver_if.sv
// Per-channel event handshake bundle between an event source and the receiver.
// Ports: req_in (source -> receiver), ack_out and busy_o (receiver -> source).
// master = event source side, slave = event_hs_receiver side.
interface event_hs_receiver_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] req_in;   // per-channel sysReq event level
  logic [NUM_CH-1:0] ack_out;  // per-channel registered ack
  logic [NUM_CH-1:0] busy_o;   // per-channel receiver busy (not IDLE)

  modport master (
    output req_in,
    input  ack_out,
    input  busy_o
  );

  modport slave (
    input  req_in,
    output ack_out,
    output busy_o
  );
endinterface

// File: rtl/event_hs_receiver.sv
// Multi-channel event handshake receiver: each channel acks its sysReq level
//   immediately, after programmable rise/fall delays, or not at all (no-ack mode),
//   counts clean handshakes, and reports the first protocol/timeout error.
// Ports: clk, rst_n (async active-low); hs (req_in/ack_out/busy_o bundle);
//   mode_i, rise_dly_i, fall_dly_i latched per channel at handshake start;
//   to_thresh_i timeout in units of 4096 cycles (0 = off); hs_cnt_o packed
//   per-channel counters; err_vld_o/err_type_o/err_ch_o sticky error record,
//   cleared by err_clr_i.
// Latency: ack 1 cycle after req sampled high (immediate) or rise_dly+1 (delayed).
// Backpressure: none; channels are fully independent, only the error record is shared.
// Build option: define EVENT_HS_TIMEOUT_EN to include the per-channel timeout
//   timers; without it to_thresh_i is ignored and no timeout error exists.
module event_hs_receiver #(
  parameter  int NUM_CH = 4,
  parameter  int DLY_W  = 8,
  parameter  int CNT_W  = 16,
  parameter  int TO_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  event_hs_receiver_if.slave      hs,
  input  logic [1:0]              mode_i,
  input  logic [DLY_W-1:0]        rise_dly_i,
  input  logic [DLY_W-1:0]        fall_dly_i,
  input  logic [TO_W-1:0]         to_thresh_i,
  output logic [NUM_CH*CNT_W-1:0] hs_cnt_o,
  output logic                    err_vld_o,
  output logic [1:0]              err_type_o,
  output logic [CH_W-1:0]         err_ch_o,
  input  logic                    err_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE_WAIT,
    S_ACKED,
    S_FALL_WAIT,
    S_NOACK,
    S_RECOVER
  } state_t;

  localparam logic [1:0] MODE_DLY   = 2'b01;
  localparam logic [1:0] MODE_NOACK = 2'b10;
  localparam logic [1:0] ERR_PROT   = 2'b01;
  localparam logic [1:0] ERR_TO     = 2'b10;

  wire [NUM_CH-1:0]       ack_vec;
  wire [NUM_CH-1:0]       busy_vec;
  wire [NUM_CH-1:0]       perr_vec;   // protocol error pulse per channel
  wire [NUM_CH-1:0]       to_vec;     // timeout error pulse per channel
  wire [NUM_CH*CNT_W-1:0] cnt_vec;

  assign hs.ack_out = ack_vec;
  assign hs.busy_o  = busy_vec;
  assign hs_cnt_o   = cnt_vec;

`ifndef EVENT_HS_TIMEOUT_EN
  // Threshold has no consumer when the timers are compiled out.
  logic unused_to_thresh;
  assign unused_to_thresh = ^to_thresh_i;
`endif

  // ---------------------------------------------------------------------------
  // Per-channel handshake engine
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;   // rise/fall delay countdown
    logic [DLY_W-1:0] fdly_q, fdly_d;   // fall delay captured at handshake start
    logic             imm_q, imm_d;     // captured immediate mode: fall delay ignored
    logic             rec_q, rec_d;     // second RECOVER cycle marker
    logic             errf_q, errf_d;   // current handshake hit an error
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req;
    logic             to_hit;
    logic             perr;

    assign req = hs.req_in[g];

`ifdef EVENT_HS_TIMEOUT_EN
    // Timer counts cycles since the IDLE exit edge (that edge counts as 1) and
    // runs only while req stays high; it fires once when the count reaches
    // to_thresh_i*4096, then stops so the error is not raised again.
    localparam int TMR_W = TO_W + 12;
    logic [TMR_W-1:0] tmr_q;
    logic             run_q;
    logic [TMR_W-1:0] tmr_lim;
    logic             tmr_start;

    assign tmr_lim   = {to_thresh_i, 12'd0};
    assign tmr_start = (state_q == S_IDLE) && req;
    assign to_hit    = run_q && req && (to_thresh_i != '0) &&
                       (tmr_q == tmr_lim - TMR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tmr_q <= '0;
        run_q <= 1'b0;
      end else if (tmr_start) begin
        tmr_q <= TMR_W'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        if (!req || to_hit) begin
          run_q <= 1'b0;
        end else begin
          tmr_q <= tmr_q + TMR_W'(1);
        end
      end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next-state and output logic
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      fdly_d  = fdly_q;
      imm_d   = imm_q;
      rec_d   = rec_q;
      errf_d  = errf_q;
      ack_d   = ack_q;
      cnt_d   = cnt_q;
      perr    = 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            errf_d = 1'b0;
            fdly_d = fall_dly_i;
            if (mode_i == MODE_NOACK) begin
              imm_d   = 1'b0;
              state_d = S_NOACK;
            end else if (mode_i == MODE_DLY) begin
              imm_d = 1'b0;
              if (rise_dly_i == '0) begin
                ack_d   = 1'b1;
                state_d = S_ACKED;
              end else begin
                dcnt_d  = rise_dly_i;
                state_d = S_RISE_WAIT;
              end
            end else begin
              // 00 and the reserved 11 encoding both ack immediately.
              imm_d   = 1'b1;
              ack_d   = 1'b1;
              state_d = S_ACKED;
            end
          end
        end

        S_RISE_WAIT: begin
          if (!req) begin
            // Source withdrew the event before we acked it.
            perr    = 1'b1;
            errf_d  = 1'b1;
            state_d = S_RECOVER;
          end else if (to_hit) begin
            errf_d  = 1'b1;
            state_d = S_NOACK;
          end else if (dcnt_q <= DLY_W'(1)) begin
            ack_d   = 1'b1;
            state_d = S_ACKED;
          end else begin
            dcnt_d = dcnt_q - DLY_W'(1);
          end
        end

        S_ACKED: begin
          if (!req) begin
            state_d = S_FALL_WAIT;
            if (imm_q || (fdly_q == '0)) begin
              // Drop ack now; FALL_WAIT then passes straight to RECOVER.
              ack_d  = 1'b0;
              dcnt_d = '0;
            end else begin
              dcnt_d = fdly_q;
            end
          end else if (to_hit) begin
            errf_d  = 1'b1;
            ack_d   = 1'b0;
            state_d = S_NOACK;
          end
        end

        S_FALL_WAIT: begin
          if (dcnt_q <= DLY_W'(1)) begin
            ack_d   = 1'b0;
            state_d = S_RECOVER;
          end else begin
            dcnt_d = dcnt_q - DLY_W'(1);
          end
        end

        S_NOACK: begin
          if (!req) begin
            state_d = S_RECOVER;
          end else if (to_hit) begin
            errf_d = 1'b1;
          end
        end

        S_RECOVER: begin
          if (rec_q) begin
            rec_d   = 1'b0;
            state_d = S_IDLE;
            if (!errf_q && (cnt_q != '1)) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            rec_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        dcnt_q  <= '0;
        fdly_q  <= '0;
        imm_q   <= 1'b0;
        rec_q   <= 1'b0;
        errf_q  <= 1'b0;
        ack_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        fdly_q  <= fdly_d;
        imm_q   <= imm_d;
        rec_q   <= rec_d;
        errf_q  <= errf_d;
        ack_q   <= ack_d;
        cnt_q   <= cnt_d;
      end
    end

    assign ack_vec[g]                 = ack_q;
    assign busy_vec[g]                = (state_q != S_IDLE);
    assign perr_vec[g]                = perr;
    assign to_vec[g]                  = to_hit;
    assign cnt_vec[g*CNT_W +: CNT_W]  = cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Shared error record: first error wins, lowest channel wins a tie
  // ---------------------------------------------------------------------------
  logic            new_err;
  logic [1:0]      new_type;
  logic [CH_W-1:0] new_ch;

  // Scan from the top so the lowest active channel is the last one written.
  always_comb begin
    new_err  = 1'b0;
    new_type = 2'b00;
    new_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (perr_vec[i] || to_vec[i]) begin
        new_err  = 1'b1;
        new_type = perr_vec[i] ? ERR_PROT : ERR_TO;
        new_ch   = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld_o  <= 1'b0;
      err_type_o <= 2'b00;
      err_ch_o   <= '0;
    end else if (new_err && (!err_vld_o || err_clr_i)) begin
      // A clear in the same cycle as a new error still keeps the new one.
      err_vld_o  <= 1'b1;
      err_type_o <= new_type;
      err_ch_o   <= new_ch;
    end else if (err_clr_i) begin
      err_vld_o  <= 1'b0;
      err_type_o <= 2'b00;
      err_ch_o   <= '0;
    end
  end

endmodule

// File: doc/event_hs_receiver.md
EVENT_HS_RECEIVER -- requirements
Module: event_hs_receiver

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent event channels (1..32).
REQ-002 Parameter DLY_W, default 8, width of the rise and fall delay inputs.
REQ-003 Parameter CNT_W, default 16, width of each per-channel handshake counter.
REQ-004 Parameter TO_W, default 16, width of the timeout threshold (units of 4096 cycles).
REQ-005 Port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port req_in, input, NUM_CH, per-channel sysReq event, synchronous to clk.
REQ-008 Port ack_out, output, NUM_CH, per-channel event ack, registered.
REQ-009 Port mode_i, input, 2, ack mode: 00 immediate, 01 delayed, 10 no-ack, 11 treated as 00.
REQ-010 Port rise_dly_i, input, DLY_W, cycles from req rise to ack rise in delayed mode.
REQ-011 Port fall_dly_i, input, DLY_W, cycles from req fall to ack fall in delayed mode.
REQ-012 Port to_thresh_i, input, TO_W, timeout threshold; 0 disables the timeout.
REQ-013 Port busy_o, output, NUM_CH, per-channel receiver busy.
REQ-014 Port hs_cnt_o, output, NUM_CH*CNT_W, completed-handshake counts; channel i at bits [i*CNT_W +: CNT_W].
REQ-015 Port err_vld_o, output, 1, sticky error-record valid.
REQ-016 Port err_type_o, output, 2, error type: 01 protocol, 10 timeout.
REQ-017 Port err_ch_o, output, $clog2(NUM_CH) (min 1), channel of the recorded error.
REQ-018 Port err_clr_i, input, 1, single-cycle pulse that clears the error record.

Function
REQ-019 Each channel SHALL run its own FSM with states IDLE, RISE_WAIT, ACKED, FALL_WAIT, NOACK, RECOVER.
REQ-020 IDLE with req_in=1 SHALL latch mode_i, rise_dly_i and fall_dly_i per channel; later input changes SHALL NOT affect the handshake in progress.
REQ-021 In immediate mode, or delayed mode with rise delay 0, ack_out SHALL rise 1 cycle after req_in is first sampled high; otherwise it SHALL rise rise_dly+1 cycles after.
REQ-022 In ACKED, when req_in is sampled low: with fall delay 0 (or immediate mode), ack_out SHALL fall on the next cycle; otherwise it SHALL fall fall_dly+1 cycles after.
REQ-023 No-ack mode SHALL never assert ack_out; the channel SHALL wait in NOACK for req_in low.
REQ-024 RECOVER SHALL last exactly 2 cycles and then return to IDLE.
REQ-025 busy_o[i] SHALL be 1 in every state except IDLE.
REQ-026 hs_cnt[i] SHALL increment on RECOVER exit, saturate at all-ones, and count only handshakes that completed without error.
REQ-027 Protocol error: req_in falling in RISE_WAIT SHALL abort to RECOVER with ack_out never asserted and raise error type 01.
REQ-028 Timeout: the channel timer SHALL start at IDLE exit and stop when req_in falls. Reaching to_thresh_i*4096 cycles SHALL raise error type 10, force ack_out low next cycle, and move to NOACK.
REQ-029 Error record: the first error SHALL be captured and held until err_clr_i. Later errors SHALL be dropped while err_vld_o=1.
REQ-030 Simultaneous errors on several channels SHALL record the lowest channel index.
REQ-031 If err_clr_i and a new error occur in the same cycle, the new error SHALL be recorded.
REQ-032 A handshake that has no error SHALL NOT stall any other channel.

Reset
REQ-033 rst_n low SHALL immediately set ack_out=0, busy_o=0, hs_cnt_o=0, err_vld_o=0, err_type_o=0, err_ch_o=0, all FSMs to IDLE and all timers to 0.
REQ-034 A channel mid-handshake at reset SHALL restart in IDLE after reset release. If req_in is still high, a new handshake SHALL start.

Configuration
REQ-035 Macro EVENT_HS_TIMEOUT_EN defined: timers and timeout error are present as specified.
REQ-036 Macro EVENT_HS_TIMEOUT_EN undefined: no timer logic exists, to_thresh_i is ignored, and error type 10 never occurs. NOACK then exits only on req_in low.

Verification
REQ-037 Immediate mode, ch0: req high at cycle 10, low at cycle 20 -> ack high at cycle 11, low at cycle 21; busy low at cycle 24; hs_cnt[0]=1.
REQ-038 Delayed mode, rise=5, fall=3: req high at cycle 0, low at cycle 20 -> ack high at cycle 6, low at cycle 24.
REQ-039 Delayed mode, rise=10: req pulsed for 4 cycles -> no ack; err_vld=1, type=01, ch=0; hs_cnt unchanged; err_clr clears the record.
REQ-040 Timeout build, no-ack mode, to_thresh=1: req held high -> error type 10 at cycle 4096 after req rise; channel returns to IDLE 2 cycles after req falls.
REQ-041 Channels 1 and 3 hit a protocol error in the same cycle -> err_ch=1. A later error on ch2 is ignored until err_clr.
REQ-042 Assert rst_n low while ch0 is in ACKED -> ack_out=0 asynchronously. After release with req still high, ack rises 1 cycle later.
